// File: rtl/wb_icu186.sv
// rtl/wb_icu186.sv - 80186-style nested-priority interrupt control unit on a Wishbone slave slot
// Optional POLL register at offset 0x04 is enabled by defining WB_ICU186_POLL_EN.

module wb_icu186 #(
    parameter logic [7:0] VEC_TIMER    = 8'h08,
    parameter logic [7:0] VEC_INT_BASE = 8'h0C,
    parameter logic [7:0] VEC_SPUR     = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic [3:0]  irq_i,
    input  logic        inta,
    output logic        intr,
    output logic [7:0]  vec
);

    localparam logic [3:0] A_EOI    = 4'd1;
    localparam logic [3:0] A_MASK   = 4'd4;
    localparam logic [3:0] A_REQST  = 4'd6;
    localparam logic [3:0] A_INSERV = 4'd7;
    localparam logic [3:0] A_CTRL0  = 4'd9;
    localparam logic [3:0] A_CTRL1  = 4'd12;
    localparam logic [3:0] A_CTRL2  = 4'd13;
    localparam logic [3:0] A_CTRL3  = 4'd14;
`ifdef WB_ICU186_POLL_EN
    localparam logic [3:0] A_POLL   = 4'd2;
    logic [7:0] poll_v;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    logic [3:0]  req_q, req_d, mask_q, mask_d, ltm_q, ltm_d, ins_q, ins_d;
    logic        intr_q, intr_d, ack_q, ack_d, inta_q, inta_d;
    logic [7:0]  vec_q, vec_d;
    logic [15:0] dat_q, dat_d;

    logic        access, wr, rd, take, ctrl_hit;
    logic [1:0]  ctrl_n, sel;
    logic [3:0]  rise, elig;
    logic [7:0]  eoi_v;
    logic        unused_bits;

    assign unused_bits = ^{wb_sel_i[1], wb_dat_i[14:5]};

    function automatic logic [7:0] src_vec(input logic [1:0] n);
        return (n == 2'd0) ? VEC_TIMER : VEC_INT_BASE + {6'd0, n} - 8'd1;
    endfunction

    // A source is blocked by any in-service source of equal or higher priority.
    function automatic logic [3:0] nested_elig(input logic [3:0] req, input logic [3:0] mask,
                                               input logic [3:0] ins);
        logic       blocked;
        logic [3:0] e;
        blocked = 1'b0;
        e       = 4'd0;
        for (int n = 0; n < 4; n++) begin
            blocked = blocked | ins[n];
            e[n]    = req[n] & ~mask[n] & ~blocked;
        end
        return e;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (v[n]) idx = 2'(n);
        end
        return idx;
    endfunction

    always_comb begin
        sync1_d  = irq_i;
        sync2_d  = sync1_q;
        dly_d    = sync2_q;
        inta_d   = inta;
        state_d  = state_q;
        vec_d    = vec_q;
        req_d    = req_q;
        mask_d   = mask_q;
        ltm_d    = ltm_q;
        ins_d    = ins_q;
        dat_d    = 16'd0;
        take     = 1'b0;
        eoi_v    = 8'd0;
        ctrl_hit = 1'b1;
        ctrl_n   = 2'd0;
`ifdef WB_ICU186_POLL_EN
        poll_v   = 8'd0;
`endif

        access = wb_stb_i & wb_cyc_i & ~ack_q;
        wr     = access & wb_we_i & wb_sel_i[0];
        rd     = access & ~wb_we_i;
        ack_d  = access;
        rise   = sync2_q & ~dly_q;

        case (wb_adr_i)
            A_CTRL0: ctrl_n = 2'd0;
            A_CTRL1: ctrl_n = 2'd1;
            A_CTRL2: ctrl_n = 2'd2;
            A_CTRL3: ctrl_n = 2'd3;
            default: ctrl_hit = 1'b0;
        endcase

        // Register writes land before the acknowledge selection below, so an EOI
        // in the same cycle as an ack is seen by that ack.
        if (wr) begin
            if (wb_adr_i == A_EOI) begin
                if (wb_dat_i[15]) begin
                    if (|ins_d) ins_d[lowest_set(ins_d)] = 1'b0;
                end else begin
                    for (int n = 0; n < 4; n++) begin
                        eoi_v = src_vec(2'(n));
                        if (eoi_v[4:0] == wb_dat_i[4:0]) ins_d[n] = 1'b0;
                    end
                end
            end
            if (wb_adr_i == A_MASK)   mask_d = wb_dat_i[3:0];
            if (wb_adr_i == A_INSERV) ins_d  = ins_d & ~wb_dat_i[3:0];
            if (ctrl_hit) begin
                ltm_d[ctrl_n]  = wb_dat_i[4];
                mask_d[ctrl_n] = wb_dat_i[3];
            end
        end

        elig = nested_elig(req_q, mask_d, ins_d);
        sel  = lowest_set(elig);

        if (rd) begin
            case (wb_adr_i)
                A_MASK:   dat_d = {12'd0, mask_q};
                A_REQST:  dat_d = {12'd0, req_q};
                A_INSERV: dat_d = {12'd0, ins_q};
                default:  dat_d = ctrl_hit ? {11'd0, ltm_q[ctrl_n], mask_q[ctrl_n], 3'd0} : 16'd0;
            endcase
        end

`ifdef WB_ICU186_POLL_EN
        if (rd && wb_adr_i == A_POLL && |elig) begin
            take   = 1'b1;
            poll_v = src_vec(sel);
            dat_d  = {1'b1, 10'd0, poll_v[4:0]};
        end
`endif

        case (state_q)
            S_IDLE: if (inta && !inta_q) state_d = S_ACK;
            S_ACK: begin
                state_d = S_HOLD;
                if (|elig) begin
                    vec_d = src_vec(sel);
                    take  = 1'b1;
                end else begin
                    vec_d = VEC_SPUR;
                end
            end
            S_HOLD: begin
                if (!inta) begin
                    state_d = S_IDLE;
                    vec_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = 8'd0;
            end
        endcase

        if (take) ins_d[sel] = 1'b1;

        // A fresh edge arriving with the ack wins, so the request stays pending.
        for (int n = 0; n < 4; n++) begin
            req_d[n] = ltm_q[n] ? sync2_q[n]
                                : ((req_q[n] & ~(take & (sel == 2'(n)))) | rise[n]);
        end

        intr_d = |nested_elig(req_q, mask_q, ins_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            dly_q   <= 4'd0;
            req_q   <= 4'd0;
            mask_q  <= 4'hF;
            ltm_q   <= 4'd0;
            ins_q   <= 4'd0;
            intr_q  <= 1'b0;
            ack_q   <= 1'b0;
            inta_q  <= 1'b0;
            vec_q   <= 8'd0;
            dat_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            req_q   <= req_d;
            mask_q  <= mask_d;
            ltm_q   <= ltm_d;
            ins_q   <= ins_d;
            intr_q  <= intr_d;
            ack_q   <= ack_d;
            inta_q  <= inta_d;
            vec_q   <= vec_d;
            dat_q   <= dat_d;
        end
    end

    assign intr     = intr_q;
    assign vec      = vec_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_icu186.sv
// tb/tb_wb_icu186.sv - self-checking bench for wb_icu186 against a transaction-level model

module tb_wb_icu186;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_adr_i = 4'd0;
    logic [15:0] wb_dat_i = 16'd0;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i = 2'b11;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [3:0]  irq_i = 4'd0;
    logic        inta = 1'b0;
    logic        intr;
    logic [7:0]  vec;

    wb_icu186 dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .irq_i(irq_i), .inta(inta), .intr(intr), .vec(vec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending requests, mask, trigger mode, in-service set.
    logic [3:0] m_req, m_mask, m_ltm, m_ins;
    logic [7:0] m_vtab [4] = '{8'h08, 8'h0C, 8'h0D, 8'h0E};
    logic [3:0] ctrl_adr [4] = '{4'd9, 4'd12, 4'd13, 4'd14};

    function automatic logic [3:0] m_elig();
        logic [3:0] e;
        logic [3:0] higher_or_same;
        e = 4'd0;
        for (int n = 0; n < 4; n++) begin
            higher_or_same = m_ins & 4'((1 << (n + 1)) - 1);
            e[n] = m_req[n] && !m_mask[n] && (higher_or_same == 4'd0);
        end
        return e;
    endfunction

    function automatic int m_first(input logic [3:0] v);
        for (int n = 0; n < 4; n++) if (v[n]) return n;
        return -1;
    endfunction

    task automatic model_reset();
        m_req = 4'd0; m_mask = 4'hF; m_ltm = 4'd0; m_ins = 4'd0;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic wb_xfer(input logic [3:0] adr, input logic [15:0] dat, input logic we,
                           input logic [1:0] sel, output logic [15:0] rdat);
        logic got;
        got  = 1'b0;
        rdat = 16'hDEAD;
        @(negedge clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) begin
                got  = 1'b1;
                rdat = wb_dat_o;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (!got) check_eq("wb_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic reg_read(input logic [3:0] adr, output logic [15:0] rdat);
        wb_xfer(adr, 16'd0, 1'b0, 2'b11, rdat);
    endtask

    task automatic reg_write(input logic [3:0] adr, input logic [15:0] dat);
        logic [15:0] dummy;
        int          n;
        wb_xfer(adr, dat, 1'b1, 2'b11, dummy);
        case (adr)
            4'd1: begin
                if (dat[15]) begin
                    n = m_first(m_ins);
                    if (n >= 0) m_ins[n] = 1'b0;
                end else begin
                    for (int k = 0; k < 4; k++) if (m_vtab[k][4:0] == dat[4:0]) m_ins[k] = 1'b0;
                end
            end
            4'd4: m_mask = dat[3:0];
            4'd7: m_ins  = m_ins & ~dat[3:0];
            default: begin
                for (int k = 0; k < 4; k++) begin
                    if (ctrl_adr[k] == adr) begin
                        m_ltm[k]  = dat[4];
                        m_mask[k] = dat[3];
                    end
                end
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] r;
        reg_read(4'd4, r); check_eq({tag, "_mask"}, r, {12'd0, m_mask});
        reg_read(4'd6, r); check_eq({tag, "_reqst"}, r, {12'd0, m_req});
        reg_read(4'd7, r); check_eq({tag, "_inserv"}, r, {12'd0, m_ins});
    endtask

    task automatic check_intr(input string tag);
        check_eq(tag, intr, |m_elig());
    endtask

    task automatic pulse_irq(input logic [3:0] bits);
        @(negedge clk);
        irq_i = irq_i | bits;
        repeat (2) @(negedge clk);
        irq_i = irq_i & ~bits;
        settle();
        for (int n = 0; n < 4; n++) if (bits[n] && !m_ltm[n]) m_req[n] = 1'b1;
    endtask

    task automatic do_inta(input string tag);
        int         s;
        logic [7:0] expv;
        s    = m_first(m_elig());
        expv = (s < 0) ? 8'h07 : m_vtab[s];
        @(negedge clk);
        inta = 1'b1;
        repeat (3) @(negedge clk);
        check_eq(tag, vec, expv);
        if (s >= 0) begin
            m_ins[s] = 1'b1;
            if (!m_ltm[s]) m_req[s] = 1'b0;
        end
        inta = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, "_release"}, vec, 32'd0);
    endtask

    task automatic do_poll(input string tag);
        logic [15:0] r;
        logic [15:0] expd;
        int          s;
        s    = m_first(m_elig());
        expd = 16'd0;
`ifdef WB_ICU186_POLL_EN
        if (s >= 0) begin
            expd = {1'b1, 10'd0, m_vtab[s][4:0]};
            m_ins[s] = 1'b1;
            if (!m_ltm[s]) m_req[s] = 1'b0;
        end
`endif
        reg_read(4'd2, r);
        check_eq(tag, r, expd);
        if (s < -1) check_eq("poll_index", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] r;
        int          op;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_intr", intr, 32'd0);
        check_eq("rst_vec", vec, 32'd0);
        check_eq("rst_ack", wb_ack_o, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        reg_read(4'd4, r);
        check_eq("mask_reset", r, 32'h000F);
        wb_xfer(4'd4, 16'h0000, 1'b1, 2'b10, r);
        reg_read(4'd4, r);
        check_eq("mask_hi_sel_ignored", r, 32'h000F);
        pulse_irq(4'b0010);
        reg_read(4'd6, r);
        check_eq("reqst_masked", r, 32'h0002);
        check_intr("intr_masked");

        // Unmask and acknowledge source 1
        reg_write(4'd4, 16'h0000);
        settle();
        check_intr("intr_unmasked");
        pulse_irq(4'b0010);
        do_inta("vec_src1");
        check_regs("after_ack1");
        check_intr("intr_after_ack1");

        // Nesting: lower priority blocked, higher priority preempts
        pulse_irq(4'b1000);
        check_intr("intr_src3_blocked");
        pulse_irq(4'b0001);
        check_intr("intr_src0_nested");
        do_inta("vec_src0");
        reg_write(4'd1, 16'h8000);
        check_regs("after_nonspec_eoi");
        reg_write(4'd1, 16'h000C);
        settle();
        check_intr("intr_src3_unblocked");
        do_inta("vec_src3");
        reg_write(4'd1, 16'h8000);

        // Simultaneous edges resolved by priority
        pulse_irq(4'b0101);
        do_inta("vec_simul_first");
        reg_write(4'd1, 16'h0008);
        do_inta("vec_simul_second");
        reg_write(4'd1, 16'h8000);
        check_regs("after_simul");

        // Level-triggered source 2
        reg_write(4'd13, 16'h0010);
        reg_read(4'd13, r);
        check_eq("ctrl2_read", r, 32'h0010);
        @(negedge clk);
        irq_i[2] = 1'b1;
        settle();
        m_req[2] = 1'b1;
        check_intr("intr_level");
        do_inta("vec_level");
        settle();
        check_intr("intr_level_in_service");
        reg_write(4'd1, 16'h000D);
        settle();
        check_intr("intr_level_reassert");
        reg_write(4'd4, 16'h000F);
        settle();
        check_intr("intr_all_masked");
        do_inta("vec_spurious");
        check_regs("after_spurious");
        @(negedge clk);
        irq_i[2] = 1'b0;
        settle();
        m_req[2] = 1'b0;
        reg_write(4'd13, 16'h0008);
        reg_write(4'd4, 16'h0000);
        check_regs("after_level");

        // Randomised traffic in edge mode
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: pulse_irq(4'(1 << $urandom_range(0, 3)) | 4'($urandom_range(0, 1) << $urandom_range(0, 3)));
                1: reg_write(4'd4, 16'($urandom_range(0, 15) & $urandom_range(0, 15)));
                2: do_inta("rnd_vec");
                3: begin
                    int k;
                    k = $urandom_range(0, 5);
                    if (k == 0)      reg_write(4'd1, 16'h8000);
                    else if (k == 5) reg_write(4'd1, 16'h001F);
                    else             reg_write(4'd1, {8'd0, m_vtab[k - 1]});
                end
                4: check_regs("rnd_regs");
                default: do_poll("rnd_poll");
            endcase
            settle();
            check_intr("rnd_intr");
        end

        // Reset while the acknowledge is holding
        reg_write(4'd7, 16'h000F);
        reg_write(4'd4, 16'h0000);
        pulse_irq(4'b0001);
        @(negedge clk);
        inta = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("hold_vec", vec, 32'h08);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midack_vec", vec, 32'd0);
        check_eq("midack_intr", intr, 32'd0);
        check_eq("midack_ack", wb_ack_o, 32'd0);
        @(negedge clk);
        inta = 1'b0;
        rst  = 1'b0;
        model_reset();
        check_regs("after_midack_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_icu186.md
Name: wb_icu186

Overview:
- 80186-style interrupt control unit occupying Wishbone slave slot s2 (I/O 0xFF20–0xFF3E) of the Zet co-processor.
- Sequences and prioritises four interrupt sources: timer, Tube IRQ, Tube NMI-as-maskable spare, and one external line.
- Drives the CPU intr request and supplies the vector on inta. It replaces the ad-hoc edge latch and the hard-wired 0x000C vector in the top level.
- Nested-priority scheduler with in-service tracking and EOI.

Parameters:
- VEC_TIMER, 8'h08, type returned for source 0 (timer).
- VEC_INT_BASE, 8'h0C, type for source n (n=1..3) is VEC_INT_BASE+n-1.
- VEC_SPUR, 8'h07, type returned when inta arrives with nothing eligible.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- wb_adr_i  in  4  word address offset [4:1] within 0xFF20–0xFF3E
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_sel_i  in  2  byte selects; writes honour only wb_sel_i[0] (low byte)
- wb_we_i  in  1  write enable
- wb_stb_i, wb_cyc_i  in  1  strobe/cycle
- wb_ack_o  out  1  acknowledge
- irq_i  in  4  async requests; bit0 = timer = highest priority, bit3 = lowest
- inta  in  1  CPU interrupt acknowledge (wb_tgc_o)
- intr  out  1  interrupt request to CPU
- vec  out  8  interrupt type, valid while inta high

Behaviour:
- Reset is synchronous, active-high, clock clk. All state clears. Outputs reset to: intr=0, vec=0, wb_ack_o=0, wb_dat_o=0. MASK resets to 4'hF (all masked). LTM resets to 0. Synchronisers reset to 0.
- Each irq_i bit passes a 2-FF synchroniser plus a delay FF.
  - Edge mode (LTM=0): a synced rising edge sets REQ[n].
  - Level mode (LTM=1): REQ[n] follows the synced level.
- Registers (byte offset from 0xFF20):
  - 0x02 EOI (W). Bit15=1: nonspecific, clears the lowest-index set INSERV bit (no-op if none). Bit15=0: bits[4:0] type; clears INSERV of the matching source. An unmatched type is a no-op.
  - 0x08 MASK (RW) bits[3:0].
  - 0x0C REQST (R) REQ[3:0].
  - 0x0E INSERV (RW). A write clears the INSERV bits written 1.
  - 0x12/0x18/0x1A/0x1C control for src0..3 (RW). Bit4=LTM, bit3=mask (aliases MASK[n]).
  - Others read 0; writes ignored.
- Wishbone timing:
  - wb_ack_o pulses for one cycle, the cycle after stb&cyc&!ack (1-cycle latency). It is never held for 2 consecutive cycles.
  - Read data is registered with the ack.
  - A write takes effect at the ack cycle.
- Eligibility: src n is eligible when REQ[n] & !MASK[n], and no INSERV[m] is set for m≤n (fully nested). intr is registered: intr = any eligible, updated every cycle.
- Acknowledge FSM with states IDLE, ACK, HOLD:
  - IDLE→ACK on inta rising edge. In ACK (one cycle), select the lowest-index eligible source s, set vec, set INSERV[s], and clear REQ[s] if edge mode. With no eligible source: vec=VEC_SPUR and no state change.
  - ACK→HOLD. vec holds stable while inta=1.
  - HOLD→IDLE when inta=0. vec returns to 0.
- Simultaneous events:
  - A new synced edge on s in the same cycle as ack → REQ[s] stays 1.
  - An EOI write and an ack in the same cycle → EOI applied first, then the ack selection uses the post-EOI INSERV.
  - A MASK write masking the pending source → intr drops the next cycle.
- Reset mid-acknowledge returns the FSM to IDLE, clears INSERV, and sets vec=0.

Optional Feature:
- Macro WB_ICU186_POLL_EN.
- Defined: offset 0x04 POLL (R) returns {intr, 10'b0, type[4:0]} of the highest eligible source. The read performs a full acknowledge (sets INSERV, clears edge REQ) at the ack cycle. With no eligible source it returns 16'h0000 with no state change.
- Undefined: 0x04 reads 0 with no side effects.

Test Plan:
- Reset → MASK read = 16'h000F; intr=0; pulse irq_i[1] → REQST reads 16'h0002, intr stays 0.
- MASK=0, pulse irq_i[1], raise inta → intr=1 within 4 clk; vec=8'h0C; INSERV=16'h0002; REQST=0; intr=0.
- INSERV[1] set, pulse irq_i[3] → intr stays 0. Pulse irq_i[0] → intr=1, vec=8'h08. Then EOI 16'h8000 → INSERV=16'h0002.
- irq_i[0] and irq_i[2] edges in the same cycle → first inta gives vec=8'h08. After EOI 16'h0008, a second inta gives vec=8'h0D.
- Set src2 LTM=1 and hold irq_i[2] high → after ack and EOI, intr reasserts. Raise inta with MASK=16'hF set beforehand → vec=8'h07, INSERV unchanged.
- Assert rst during HOLD → vec=0, INSERV=0, intr=0, and wb_ack_o=0 the next cycle.
